// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo
//   UART echo engine. Frames arriving on rx are sampled mid-bit from an
//   internal baud divider (DIV = CLK_HZ/BAUD cycles per bit), stored in a
//   FIFO, and retransmitted on tx whenever echo_en allows a new frame.
//
//   Optional feature macro: UART_ECHO_PARITY_EN
//     defined   -> even parity bit after the data bits, checked on RX and
//                  generated on TX
//     undefined -> DATA_BITS N 1 frames
//
// Ports
//   hwclk       sole clock, rising edge
//   reset       synchronous active-high reset
//   rx          asynchronous serial input, idle high
//   tx          serial output, idle high
//   echo_en     allows the transmitter to start a new frame
//   clr_err     one-cycle pulse clearing overflow and frame_err
//   fifo_count  FIFO occupancy, 0..FIFO_DEPTH
//   rx_strobe   one-cycle pulse per received frame with a good stop bit
//   tx_strobe   one-cycle pulse when a transmitted stop bit completes
//   overflow    sticky: a received byte was dropped with the FIFO full
//   frame_err   sticky: bad stop bit (or bad parity)
//
// Internal handshake: rx_push is a one-cycle valid with no ready; the FIFO
// either stores the byte or drops it (setting overflow). pop is asserted
// only when the FIFO holds data, so the read side never underflows.
module uart_echo_fifo #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          hwclk,
    input  logic                          reset,
    input  logic                          rx,
    output logic                          tx,
    input  logic                          echo_en,
    input  logic                          clr_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_strobe,
    output logic                          tx_strobe,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV) + 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [NW-1:0] FULL      = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;

    // ---------------- input synchronizer + edge detect ----------------
    logic rx_s1, rx_s2, rx_prev;
    logic rx_fall;

    always_ff @(posedge hwclk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;

    // ---------------- receiver ----------------
    state_t                 rx_state;
    logic [CW-1:0]          rx_cnt;
    logic [3:0]             rx_bit;
    logic [DATA_BITS-1:0]   rx_shift;
    logic                   rx_push;
    logic                   rx_ferr;
`ifdef UART_ECHO_PARITY_EN
    logic                   rx_par_bad;
`endif

    always_ff @(posedge hwclk) begin
        if (reset) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_push  <= 1'b0;
            rx_ferr  <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
        end else begin
            rx_push <= 1'b0;
            rx_ferr <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= ST_START;
                        rx_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        // A line back high at mid start bit is a glitch.
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
`ifdef UART_ECHO_PARITY_EN
                        rx_par_bad <= 1'b0;
`endif
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == DATA_LAST) begin
`ifdef UART_ECHO_PARITY_EN
                            rx_state <= ST_PARITY;
`else
                            rx_state <= ST_STOP;
`endif
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`ifdef UART_ECHO_PARITY_EN
                ST_PARITY: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt     <= '0;
                        rx_par_bad <= rx_s2 ^ (^rx_shift);
                        rx_state   <= ST_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_IDLE;
`ifdef UART_ECHO_PARITY_EN
                        if (!rx_s2 || rx_par_bad) rx_ferr <= 1'b1;
`else
                        if (!rx_s2) rx_ferr <= 1'b1;
`endif
                        else rx_push <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_strobe = rx_push;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 pop;
    logic                 push_ok;
    state_t               tx_state;
    logic [CW-1:0]        tx_cnt;

    // Pop from IDLE, or straight out of the last STOP cycle so that
    // consecutive frames leave no idle gap on the line.
    assign pop = echo_en && (fifo_count != '0) &&
                 ((tx_state == ST_IDLE) ||
                  (tx_state == ST_STOP && tx_cnt == BIT_LAST));
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
    assign push_ok = rx_push && ((fifo_count != FULL) || pop);

    always_ff @(posedge hwclk) begin
        if (push_ok) mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- sticky flags (set beats clear) ----------------
    always_ff @(posedge hwclk) begin
        if (reset) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_push && !push_ok) overflow <= 1'b1;
            else if (clr_err)        overflow <= 1'b0;
            if (rx_ferr)             frame_err <= 1'b1;
            else if (clr_err)        frame_err <= 1'b0;
        end
    end

    // ---------------- transmitter ----------------
    logic [3:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
`ifdef UART_ECHO_PARITY_EN
    logic                 tx_par;
`endif

    always_ff @(posedge hwclk) begin
        if (reset) begin
            tx_state  <= ST_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx        <= 1'b1;
            tx_strobe <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
            tx_par    <= 1'b0;
`endif
        end else begin
            tx_strobe <= 1'b0;
            case (tx_state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_shift <= mem[rd_ptr];
`ifdef UART_ECHO_PARITY_EN
                        tx_par   <= ^mem[rd_ptr];
`endif
                        tx       <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == DATA_LAST) begin
`ifdef UART_ECHO_PARITY_EN
                            tx       <= tx_par;
                            tx_state <= ST_PARITY;
`else
                            tx       <= 1'b1;
                            tx_state <= ST_STOP;
`endif
                        end else begin
                            tx       <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`ifdef UART_ECHO_PARITY_EN
                ST_PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx       <= 1'b1;
                        tx_state <= ST_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt    <= '0;
                        tx_strobe <= 1'b1;
                        if (pop) begin
                            tx_shift <= mem[rd_ptr];
`ifdef UART_ECHO_PARITY_EN
                            tx_par   <= ^mem[rd_ptr];
`endif
                            tx       <= 1'b0;
                            tx_state <= ST_START;
                        end else begin
                            tx_state <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

endmodule
